// File: rtl/pcm_sample_fifo.sv
// PCM sample FIFO between the decimation filter and the register interface.
// First-word fall-through circular buffer with sticky error flags and a level irq.
module pcm_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             pop,
  input  logic             clear,
  input  logic             flag_clr,
  input  logic [CW-1:0]    threshold,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic             irq
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    cnt;
  logic             ovf, unf;
  logic             push_ok, pop_ok, ovf_set, unf_set;

  assign empty   = (cnt == '0);
  assign full    = (cnt == DEPTH_C);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign pop_ok  = pop && !empty;
  assign push_ok = in_valid && (!full || pop);
  assign ovf_set = in_valid && full && !pop;
  assign unf_set = pop && empty;

  always_ff @(posedge clk) begin
    if (push_ok && !clear && !rst) mem[wptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (pop_ok)  rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      if (push_ok && !pop_ok)      cnt <= cnt + 1'b1;
      else if (pop_ok && !push_ok) cnt <= cnt - 1'b1;
    end
  end

  // Setting events win over flag_clr; clear/rst win over everything.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (ovf_set)       ovf <= 1'b1;
      else if (flag_clr) ovf <= 1'b0;
      if (unf_set)       unf <= 1'b1;
      else if (flag_clr) unf <= 1'b0;
    end
  end

  assign out_data  = empty ? '0 : mem[rptr];
  assign count     = cnt;
  assign overflow  = ovf;
  assign underflow = unf;
  assign irq       = (threshold != '0) && (cnt >= threshold);
endmodule

// File: doc/pcm_sample_fifo.md
PCM_SAMPLE_FIFO -- requirements
Module: pcm_sample_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16, PCM sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, entry count; power of two, at least 2.
REQ-003 SHALL have parameter CW, default log2(DEPTH)+1, width of count and threshold.
REQ-004 SHALL have port clk  input  1  the single clock (TinyQV project clock); all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-006 SHALL have port in_valid  input  1  one-cycle push strobe from the decimation filter, already in clk domain.
REQ-007 SHALL have port in_data  input  WIDTH  sample qualified by in_valid.
REQ-008 SHALL have port pop  input  1  one-cycle read strobe from the register interface (PCM data read).
REQ-009 SHALL have port clear  input  1  synchronous flush request.
REQ-010 SHALL have port flag_clr  input  1  clears the sticky error flags.
REQ-011 SHALL have port threshold  input  CW  interrupt level; 0 disables the interrupt.
REQ-012 SHALL have port out_data  output  WIDTH  head sample, first-word fall-through.
REQ-013 SHALL have port count  output  CW  number of stored samples, 0..DEPTH.
REQ-014 SHALL have port empty  output  1  count == 0.
REQ-015 SHALL have port full  output  1  count == DEPTH.
REQ-016 SHALL have port overflow  output  1  sticky: a push was dropped.
REQ-017 SHALL have port underflow  output  1  sticky: a pop hit an empty FIFO.
REQ-018 SHALL have port irq  output  1  level interrupt.

Function
REQ-019 SHALL keep a DEPTH x WIDTH circular buffer, with write pointer, read pointer and count registers; pointers wrap from DEPTH-1 to 0.
REQ-020 SHALL accept a push when in_valid=1 and not full: the sample is stored at the write pointer and the write pointer advances.
REQ-021 SHALL drop a push when in_valid=1 and full with no pop that cycle: stored data and pointers unchanged, overflow set to 1 on the next edge.
REQ-022 SHALL accept a pop when pop=1 and not empty: the read pointer advances.
REQ-023 SHALL ignore a pop when empty: pointers unchanged, underflow set to 1 on the next edge.
REQ-024 SHALL handle push and pop in the same cycle when full by performing both; count stays DEPTH and overflow is not set.
REQ-025 SHALL handle push and pop in the same cycle when empty by accepting the push, ignoring the pop and setting underflow; count becomes 1.
REQ-026 SHALL handle push and pop in the same cycle otherwise by performing both; count unchanged.
REQ-027 SHALL update count in the cycle after the strobe: +1 on an accepted push only, -1 on an accepted pop only.
REQ-028 SHALL drive out_data combinationally as mem[read pointer] when not empty, and 0 when empty; a pushed sample is visible on out_data the cycle after its in_valid.
REQ-029 SHALL derive empty, full and irq combinationally from registered count; no extra latency.
REQ-030 SHALL drive irq = (threshold != 0) && (count >= threshold); threshold > DEPTH means irq never asserts.
REQ-031 SHALL, on clear=1, zero pointers and count and clear both flags on the next edge; clear overrides push, pop and flag setting that same cycle.
REQ-032 SHALL, on flag_clr=1, zero both flags; a flag-setting event in the same cycle wins and the flag stays 1.
REQ-033 SHALL not require memory contents to be reset; out_data masking (REQ-028) hides stale data.

Reset
REQ-034 SHALL, while rst=1, zero pointers, count, overflow and underflow on each rising edge; rst overrides every other input.
REQ-035 SHALL drive these values after reset: out_data=0, count=0, empty=1, full=0, overflow=0, underflow=0, irq=0.
REQ-036 SHALL, when reset is asserted mid-operation, discard all stored samples; the first push after rst deasserts is stored at entry 0.

Verification
REQ-037 SHALL verify basic order: push 0x1111, 0x2222, 0x3333 -> count=3, out_data=0x1111; three pops yield 0x1111, 0x2222, 0x3333, then empty=1 and out_data=0.
REQ-038 SHALL verify full and overflow: 9 pushes of 0x0001..0x0009 with DEPTH=8 -> full=1, overflow=1, 0x0009 absent; draining yields 0x0001..0x0008.
REQ-039 SHALL verify simultaneous strobes: push+pop when full -> count stays 8, overflow=0; push+pop when empty -> count=1, underflow=1, out_data = the pushed value.
REQ-040 SHALL verify irq: threshold=4; irq=0 after 3 pushes, irq=1 after the 4th, irq=0 after one pop; threshold=0 -> irq=0 at any count.
REQ-041 SHALL verify pointer wrap: 20 push/pop pairs of values 0..19 -> each popped value equals the value pushed, count never exceeds 1.
REQ-042 SHALL verify clear and reset: clear asserted with in_valid in the same cycle -> count=0, flags=0, sample not stored; rst with count=5 -> all outputs at their REQ-035 values on the next cycle.
